// File: rtl/oarb.sv
// oarb: output-port arbiter for a packet switch.
// Grants one input at a time in round-robin order, holds the grant until the
// packet's TAIL word (or an abort, or a hold timeout), then idles one cycle.
module oarb #(
  parameter int         NIN  = 4,
  parameter int         TMO  = 256,
  parameter logic [1:0] TAIL = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NIN-1:0]         req,
  input  logic [2*NIN-1:0]       ptype,
  output logic [NIN-1:0]         ack,
  output logic [$clog2(NIN)-1:0] sel,
  output logic                   busy,
  output logic                   tmo_err
);

  localparam int SW  = $clog2(NIN);
  localparam int SW1 = SW + 1;
  localparam int CW  = $clog2(TMO + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [NIN-1:0] ack_reg, ack_next;
  logic [SW-1:0]  sel_reg, sel_next;
  logic [SW-1:0]  rr_reg, rr_next;
  logic [CW-1:0]  hold_reg, hold_next;
  logic           tmo_reg, tmo_next;
  logic [SW-1:0]  win;
  logic           found;
  logic [SW:0]    cand;
  logic [1:0]     ptype_arr [NIN];

  // Split the packed per-port type codes into one 2-bit field per input.
  generate
    for (genvar gi = 0; gi < NIN; gi++) begin : g_ptype
      assign ptype_arr[gi] = ptype[2*gi+1:2*gi];
    end
  endgenerate

  // Round-robin search: first requesting input at or above rr_reg, wrapping.
  // Scanned from the far end so the nearest requester is the last one written.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int off = NIN - 1; off >= 0; off--) begin
      cand = {1'b0, rr_reg} + SW1'(off);
      if (cand >= SW1'(NIN)) cand = cand - SW1'(NIN);
      if (req[cand[SW-1:0]]) begin
        found = 1'b1;
        win   = cand[SW-1:0];
      end
    end
  end

  // Next-state logic: grant from IDLE, release on TAIL/abort/timeout from BUSY.
  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    sel_next   = sel_reg;
    rr_next    = rr_reg;
    hold_next  = hold_reg;
    tmo_next   = tmo_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = BUSY;
          ack_next      = '0;
          ack_next[win] = 1'b1;
          sel_next      = win;
          hold_next     = '0;
        end
      end
      BUSY: begin
        // Counter never exceeds TMO because the grant is released at TMO-1.
        hold_next = hold_reg + 1'b1;
        if (!req[sel_reg] || (ptype_arr[sel_reg] == TAIL) ||
            (hold_reg == CW'(TMO - 1))) begin
          state_next = IDLE;
          ack_next   = '0;
          rr_next    = (sel_reg == SW'(NIN - 1)) ? '0 : sel_reg + 1'b1;
          // Only a genuine timeout flags an error; TAIL and abort win ties.
          if (req[sel_reg] && (ptype_arr[sel_reg] != TAIL)) tmo_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ack_next   = '0;
      end
    endcase
  end

  // State registers; reset clears the grant asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ack_reg   <= '0;
      sel_reg   <= '0;
      rr_reg    <= '0;
      hold_reg  <= '0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      sel_reg   <= sel_next;
      rr_reg    <= rr_next;
      hold_reg  <= hold_next;
      tmo_reg   <= tmo_next;
    end
  end

  assign ack     = ack_reg;
  assign sel     = sel_reg;
  assign busy    = (state_reg == BUSY);
  assign tmo_err = tmo_reg;

endmodule

// File: tb/tb_oarb.sv
// tb_oarb: scenario tasks plus randomized traffic, checked against a
// packet-level model of the arbiter kept in the bench.
module tb_oarb;

  localparam int         NIN  = 4;
  localparam int         TMO  = 8;
  localparam logic [1:0] TAIL = 2'b10;

  logic           clk = 1'b0;
  logic           rst;
  logic [NIN-1:0] req;
  logic [7:0]     ptype;
  logic [NIN-1:0] ack;
  logic [1:0]     sel;
  logic           busy;
  logic           tmo_err;

  int errors = 0;
  int checks = 0;

  // Model: which input currently owns the output (-1 = none), who goes
  // first next time, cycles since grant, last granted index, sticky error.
  int m_owner, m_rr, m_held, m_sel;
  bit m_err;

  oarb #(.NIN(NIN), .TMO(TMO), .TAIL(TAIL)) dut (
    .clk(clk), .rst(rst), .req(req), .ptype(ptype),
    .ack(ack), .sel(sel), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tailv(input int i);
    logic [7:0] t;
    t = {6'b0, TAIL};
    return t << (2 * i);
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_rr = 0; m_held = 0; m_sel = 0; m_err = 1'b0;
  endfunction

  // Packet-level rule set applied once per rising edge.
  function automatic void model_step(input logic [3:0] r, input logic [7:0] p);
    if (m_owner < 0) begin
      for (int k = 0; k < NIN; k++) begin
        if (m_owner < 0 && r[(m_rr + k) % NIN]) begin
          m_owner = (m_rr + k) % NIN;
          m_sel   = m_owner;
          m_held  = 0;
        end
      end
    end else begin
      bit done;
      done = (r[m_owner] == 1'b0) || (p[2*m_owner +: 2] == TAIL);
      if (!done && m_held == TMO - 1) begin
        done  = 1'b1;
        m_err = 1'b1;
      end
      if (done) begin
        m_rr    = (m_owner + 1) % NIN;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [3:0] a;
    a = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {a, 2'(m_sel), (m_owner >= 0), m_err};
  endfunction

  // One clock: drive inputs, advance model at the edge, return at negedge.
  task automatic cyc(input logic [3:0] r, input logic [7:0] p);
    req = r; ptype = p;
    @(posedge clk);
    model_step(r, p);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; ptype = '0; rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; ptype = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, sel, busy, tmo_err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", {ack, sel, busy, tmo_err}, 8'b0);
    end
    rst = 1'b1;
    cyc(4'b0000, 8'h00);
    checks++;
    if ({ack, sel, busy, tmo_err} !== exp_vec()) begin
      errors++;
      $display("FAIL idle_no_req: got %b expected %b", {ack, sel, busy, tmo_err}, exp_vec());
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    cyc(4'b0100, 8'h00);
    checks++;
    if (ack !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got ack=%b sel=%0d busy=%b expected ack=0100 sel=2 busy=1", ack, sel, busy);
    end
    repeat (3) cyc(4'b0100, 8'h00);
    cyc(4'b0100, tailv(2));
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_release: got ack=%b busy=%b sel=%0d expected ack=0000 busy=0 sel=2", ack, busy, sel);
    end
    cyc(4'b1111, 8'h00);
    checks++;
    if (ack !== 4'b1000) begin
      errors++;
      $display("FAIL single_rr_next: got ack=%b expected 1000", ack);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 8'h00);
      checks++;
      if (ack !== (4'b0001 << order[k]) || {ack, sel, busy, tmo_err} !== exp_vec()) begin
        errors++;
        $display("FAIL rr_grant%0d: got ack=%b expected ack=%b", k, ack, 4'b0001 << order[k]);
      end
      cyc(4'b1111, 8'h00);
      cyc(4'b1111, 8'h00);
      cyc(4'b1111, tailv(order[k]));
      checks++;
      if (ack !== 4'b0000) begin
        errors++;
        $display("FAIL rr_idle_gap%0d: got ack=%b expected 0000", k, ack);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_lock();
    do_reset();
    cyc(4'b0010, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1011, 8'hFF ^ tailv(1));
      checks++;
      if (ack !== 4'b0010) begin
        errors++;
        $display("FAIL lock_hold%0d: got ack=%b expected 0010", k, ack);
      end
    end
    cyc(4'b1011, tailv(1));
    checks++;
    if (ack !== 4'b0000) begin
      errors++;
      $display("FAIL lock_release: got ack=%b expected 0000", ack);
    end
    cyc(4'b1011, 8'h00);
    checks++;
    if (ack !== 4'b1000 || sel !== 2'd3) begin
      errors++;
      $display("FAIL lock_next: got ack=%b sel=%0d expected ack=1000 sel=3", ack, sel);
    end
    $display("test_lock done");
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    cyc(4'b0001, 8'h00);
    n = 0;
    for (int k = 0; k < 20 && ack == 4'b0001; k++) begin
      n++;
      cyc(4'b0001, 8'h00);
    end
    checks++;
    if (n !== TMO || tmo_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_len: got held=%0d tmo_err=%b expected held=%0d tmo_err=1", n, tmo_err, TMO);
    end
    cyc(4'b0100, 8'h00);
    cyc(4'b0100, tailv(2));
    cyc(4'b0000, 8'h00);
    checks++;
    if (tmo_err !== 1'b1 || {ack, sel, busy, tmo_err} !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected %b", {ack, sel, busy, tmo_err}, exp_vec());
    end
    $display("test_timeout done");
  endtask

  task automatic test_tail_vs_timeout();
    do_reset();
    cyc(4'b0010, 8'h00);
    repeat (TMO - 1) cyc(4'b0010, 8'h00);
    cyc(4'b0010, tailv(1));
    checks++;
    if (ack !== 4'b0000 || tmo_err !== 1'b0) begin
      errors++;
      $display("FAIL tail_beats_tmo: got ack=%b tmo_err=%b expected ack=0000 tmo_err=0", ack, tmo_err);
    end
    $display("test_tail_vs_timeout done");
  endtask

  task automatic test_abort_and_reset();
    do_reset();
    cyc(4'b0100, 8'h00);
    cyc(4'b0000, 8'h00);
    checks++;
    if (ack !== 4'b0000 || tmo_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: got ack=%b busy=%b tmo_err=%b expected 0000/0/0", ack, busy, tmo_err);
    end
    cyc(4'b1000, 8'h00);
    checks++;
    if (ack !== 4'b1000) begin
      errors++;
      $display("FAIL pre_reset_grant: got ack=%b expected 1000", ack);
    end
    req = 4'b1000;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ack, sel, busy, tmo_err} !== 8'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", {ack, sel, busy, tmo_err}, 8'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc(4'b1111, 8'h00);
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_grant: got ack=%b expected 0001", ack);
    end
    $display("test_abort_and_reset done");
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [7:0] p;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
      p = 8'($urandom);
      cyc(r, p);
      checks++;
      if ({ack, sel, busy, tmo_err} !== exp_vec() || $countones(ack) > 1) begin
        errors++;
        $display("FAIL random_cyc%0d: got %b expected %b", k, {ack, sel, busy, tmo_err}, exp_vec());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b0; req = '0; ptype = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_tail_vs_timeout();
    test_abort_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oarb.md
OARB -- requirements
Module: oarb

Interface
REQ-001 Parameter NIN, default 4, SHALL set the number of input ports competing for this output port (2..8).
REQ-002 Parameter TMO, default 256, SHALL set the maximum cycles one grant may be held before forced release.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous assert, active-low (0 = reset), synchronous deassert by the system.
REQ-005 req  input  NIN  SHALL carry bit i = input port i requests this output.
REQ-006 ptype  input  2*NIN  SHALL carry bits [2i+1:2i] = packet-type code of the word input i currently presents (`HEAD`, `TAIL`, other = body/idle, per the switch header).
REQ-007 ack  output  NIN  SHALL be the one-hot (or zero) grant vector returned to input ports.
REQ-008 sel  output  clog2(NIN)  SHALL be the index of the granted input, driving the crossbar mux select.
REQ-009 busy  output  1  SHALL be high while a grant is held.
REQ-010 tmo_err  output  1  SHALL be a sticky flag set on any forced timeout release.

Function
REQ-011 The block SHALL implement two states: IDLE (no grant) and BUSY (grant held).
REQ-012 In IDLE with req != 0, the winner SHALL be the first set req bit searching upward from rr_ptr with wrap-around (NIN-1 -> 0).
REQ-013 Grant SHALL be registered: req sampled high in cycle N -> ack[winner]=1, busy=1, sel=winner from cycle N+1.
REQ-014 In IDLE with req == 0, state, rr_ptr and outputs SHALL be unchanged (ack=0, busy=0).
REQ-015 In BUSY, ack SHALL remain exactly one-hot on sel regardless of other req bits changing.
REQ-016 In BUSY, if ptype[sel] == `TAIL` and req[sel] == 1 in cycle M, the grant SHALL be held through cycle M (tail word transfers) and released at cycle M+1: ack=0, busy=0, state IDLE.
REQ-017 On any release, rr_ptr SHALL become (sel+1) mod NIN, so the just-served input has lowest priority next arbitration.
REQ-018 After release, at least one IDLE cycle SHALL occur before the next grant (ack all-zero for >= 1 cycle).
REQ-019 In BUSY, if req[sel] == 0 (requester aborted), release SHALL occur the next cycle as in REQ-016, with no error flagged.
REQ-020 A hold counter SHALL clear on grant and increment each BUSY cycle; saturate-free width clog2(TMO+1).
REQ-021 If the hold counter reaches TMO-1 while still BUSY with no TAIL/abort that cycle, release SHALL occur the next cycle and tmo_err SHALL set.
REQ-022 If TAIL and timeout coincide in the same cycle, TAIL SHALL take precedence; tmo_err SHALL not set.
REQ-023 ptype of non-granted inputs SHALL be ignored; `HEAD` on ptype is not required to trigger a grant (req alone does).
REQ-024 sel SHALL hold its last value while IDLE.
REQ-025 ack SHALL never have more than one bit set in any cycle.

Reset
REQ-026 While rst=0, asynchronously: state=IDLE, ack=0, sel=0, busy=0, tmo_err=0, rr_ptr=0, hold counter=0.
REQ-027 Reset asserted mid-BUSY SHALL drop ack immediately (same cycle, asynchronously) and discard the grant.
REQ-028 tmo_err SHALL clear only by reset.

Verification
REQ-029 Single requester: NIN=4, req=0100 at cycle 1 -> ack=0100, sel=2, busy=1 at cycle 2; ptype[2]=`TAIL` at cycle 6 -> ack=0 at cycle 7, rr_ptr=3.
REQ-030 Round-robin fairness: req=1111 held, each packet 3 words ending in `TAIL` -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-031 Lock: granted input 1, req changes to 1011 mid-packet -> ack stays 0010 until cycle after ptype[1]=`TAIL`; next grant goes to input 3.
REQ-032 Timeout: TMO=8, input 0 granted, never sends TAIL -> ack=0 exactly 8 cycles after grant, tmo_err=1 and stays 1 through later normal packets.
REQ-033 Abort and reset: granted input 2 drops req -> ack=0 next cycle, tmo_err=0; separately rst=0 mid-BUSY -> ack=0 immediately, after rst release first grant searches from input 0.
